// File: rtl/dice_roller.sv
// Random die-face source: free-running 8-bit LFSR with rejection of 0/7,
// automatic bonus re-rolls on secthrow and a foul flag when the chain overruns.
module dice_roller #(
   parameter logic [7:0] SEED       = 8'hA5,
   parameter int         MAX_REROLL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       roll_req,
   input  logic       secthrow,
   output logic [2:0] state,
   output logic       state_valid,
   output logic       busy,
   output logic       foul,
   output logic [1:0] dbg_fsm
);

   // All-zero is the LFSR lock-up state, so it can never be a seed.
   localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [2:0] MAX_CHAIN = 3'(MAX_REROLL);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ROLL    = 2'd1,
      S_PRESENT = 2'd2
   } fsm_e;

   fsm_e       fsm_q, fsm_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [2:0] chain_q, chain_d;
   logic [2:0] state_q, state_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       foul_q, foul_d;
   logic [2:0] cand;
   logic       cand_ok;

   assign cand    = lfsr_q[2:0];
   assign cand_ok = (cand != 3'd0) && (cand != 3'd7);

   // Handshake: roll_req is taken only while busy=0; each accepted request
   // yields one or more state_valid pulses and ends with busy dropping.
   always_comb begin
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      fsm_d   = fsm_q;
      chain_d = chain_q;
      state_d = state_q;
      valid_d = 1'b0;
      foul_d  = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (roll_req) begin
               chain_d = 3'd0;
               fsm_d   = S_ROLL;
            end
         end
         S_ROLL: begin
            if (cand_ok) begin
               state_d = cand;
               valid_d = 1'b1;
               fsm_d   = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (!secthrow) begin
               fsm_d = S_IDLE;
            end else if (chain_q < MAX_CHAIN) begin
               chain_d = chain_q + 3'd1;
               fsm_d   = S_ROLL;
            end else begin
               foul_d = 1'b1;
               fsm_d  = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
      busy_d = (fsm_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= S_IDLE;
         lfsr_q  <= SEED_EFF;
         chain_q <= 3'd0;
         state_q <= 3'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         foul_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         lfsr_q  <= lfsr_d;
         chain_q <= chain_d;
         state_q <= state_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         foul_q  <= foul_d;
      end
   end

   assign state       = state_q;
   assign state_valid = valid_q;
   assign busy        = busy_q;
   assign foul        = foul_q;
   assign dbg_fsm     = fsm_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: two instances (MAX_REROLL 2 and 0) checked against a
// roll-sequence model derived from the LFSR sequence indexed by cycle count.
module tb_dice_roller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, st_a, req_b, st_b;
   logic [2:0] state_a, state_b;
   logic       valid_a, valid_b, busy_a, busy_b, foul_a, foul_b;
   logic [1:0] dbg_a, dbg_b;

   always #5 clk = ~clk;

   dice_roller #(.SEED(8'hA5), .MAX_REROLL(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .roll_req(req_a), .secthrow(st_a),
      .state(state_a), .state_valid(valid_a), .busy(busy_a), .foul(foul_a),
      .dbg_fsm(dbg_a)
   );

   dice_roller #(.SEED(8'hA5), .MAX_REROLL(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .roll_req(req_b), .secthrow(st_b),
      .state(state_b), .state_valid(valid_b), .busy(busy_b), .foul(foul_b),
      .dbg_fsm(dbg_b)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   int         pcnt     = 0;
   logic [7:0] lf[$];
   int         face_cnt[8];
   logic       sel = 1'b0;

   logic [2:0] obs_state;
   logic       obs_valid, obs_busy, obs_foul;
   logic [1:0] obs_dbg;

   assign obs_state = sel ? state_b : state_a;
   assign obs_valid = sel ? valid_b : valid_a;
   assign obs_busy  = sel ? busy_b  : busy_a;
   assign obs_foul  = sel ? foul_b  : foul_a;
   assign obs_dbg   = sel ? dbg_b   : dbg_a;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, pcnt);
      end
   endtask

   // k-th element = LFSR content during the k-th cycle after reset release.
   function automatic logic [7:0] lf_at(input int k);
      logic [7:0] x;
      while (lf.size() <= k) begin
         x = lf[lf.size()-1];
         lf.push_back({x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]});
      end
      return lf[k];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) pcnt++;
      @(negedge clk);
   endtask

   // mode 0: secthrow=0, mode 1: secthrow=(state==6), mode 2: secthrow=1.
   task automatic run_request(input logic s, input int mode, input bit hold);
      int         trig, vcyc, links, maxr, j;
      logic [7:0] x;
      logic [2:0] face;
      logic       sth;
      sel  = s;
      maxr = s ? 0 : 2;
      chk("idle_before_req", 8'(obs_busy), 8'd0);
      if (s) req_b = 1'b1; else req_a = 1'b1;
      trig  = pcnt;
      links = 0;
      tick();
      if (!hold) begin
         req_a = 1'b0;
         req_b = 1'b0;
      end
      while (1) begin
         j = 1;
         x = lf_at(trig + 1);
         while (x[2:0] == 3'd0 || x[2:0] == 3'd7) begin
            j++;
            x = lf_at(trig + j);
         end
         vcyc = trig + j + 1;
         face = x[2:0];
         while (pcnt < vcyc) begin
            chk("no_early_valid", 8'(obs_valid), 8'd0);
            chk("busy_in_roll", 8'(obs_busy), 8'd1);
            chk("no_foul_in_roll", 8'(obs_foul), 8'd0);
            tick();
         end
         chk("valid_pulse", 8'(obs_valid), 8'd1);
         chk("face", 8'(obs_state), 8'(face));
         chk("busy_present", 8'(obs_busy), 8'd1);
         chk("foul_not_with_valid", 8'(obs_foul), 8'd0);
         if (obs_state >= 3'd1 && obs_state <= 3'd6) face_cnt[obs_state]++;
         sth = (mode == 2) || (mode == 1 && obs_state == 3'd6);
         if (s) st_b = sth; else st_a = sth;
         if (sth && links < maxr) begin
            links++;
            trig = pcnt;
            tick();
            st_a = 1'b0;
            st_b = 1'b0;
         end else begin
            tick();
            st_a = 1'b0;
            st_b = 1'b0;
            chk("busy_after", 8'(obs_busy), 8'd0);
            chk("valid_after", 8'(obs_valid), 8'd0);
            chk("foul_after", 8'(obs_foul), 8'(sth));
            chk("fsm_idle", 8'(obs_dbg), 8'd0);
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0;
      st_a  = 1'b0;
      req_b = 1'b0;
      st_b  = 1'b0;
      lf.push_back(8'hA5);
      for (int f = 0; f < 8; f++) face_cnt[f] = 0;
      repeat (3) @(negedge clk);
      chk("rst_state", 8'(state_a), 8'd0);
      chk("rst_valid", 8'(valid_a), 8'd0);
      chk("rst_busy", 8'(busy_a), 8'd0);
      chk("rst_foul", 8'(foul_a), 8'd0);
      chk("rst_fsm", 8'(dbg_a), 8'd0);
      rst_n = 1'b1;
      pcnt  = 0;

      repeat (3) run_request(1'b0, 0, 1'b0);

      // Reset in the middle of a roll: outputs clear asynchronously.
      sel   = 1'b0;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midroll_state", 8'(state_a), 8'd0);
      chk("midroll_valid", 8'(valid_a), 8'd0);
      chk("midroll_busy", 8'(busy_a), 8'd0);
      chk("midroll_foul", 8'(foul_a), 8'd0);
      chk("midroll_fsm", 8'(dbg_a), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pcnt  = 0;
      repeat (2) run_request(1'b0, 0, 1'b0);

      for (int i = 0; i < 6000; i++) begin
         run_request(1'b0, 0, 1'b0);
         repeat ($urandom_range(0, 2)) tick();
      end

      for (int i = 0; i < 300; i++) begin
         run_request(1'b0, 1, 1'b0);
         repeat ($urandom_range(0, 1)) tick();
      end

      repeat (2) run_request(1'b0, 2, 1'b0);
      repeat (2) run_request(1'b1, 2, 1'b0);
      for (int i = 0; i < 50; i++) run_request(1'b1, 1, 1'b0);

      // roll_req held high: each new roll starts only in the idle cycle.
      for (int i = 0; i < 40; i++) run_request(1'b0, 0, 1'b1);
      req_a = 1'b0;
      tick();
      chk("hold_release_idle", 8'(busy_a), 8'd0);

      for (int f = 1; f <= 6; f++) chk("face_seen", 8'(face_cnt[f] > 0), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
